// File: rtl/hazard_ctrl_md_pkg.sv
// Shared definitions for the hazard controller with multi-cycle MD tracking.
// Contents: forwarding select codes, bus typedefs, enable levels and the
// MD unit FSM state encoding.
package hazard_ctrl_md_pkg;

  localparam int FWD_W      = 2;
  localparam int REG_ADDR_W = 5;

  typedef logic [FWD_W-1:0]      fwd_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;

  // Operand source selects shared by the EX and ID-branch muxes.
  localparam fwd_bus_t FWD_NO  = 2'd0;
  localparam fwd_bus_t FWD_MEM = 2'd1;
  localparam fwd_bus_t FWD_WB  = 2'd2;
  localparam fwd_bus_t FWD_MD  = 2'd3;

  localparam logic ENABLED  = 1'b1;
  localparam logic DISABLED = 1'b0;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/hazard_ctrl_md_md_scoreboard.sv
// Tracks the single outstanding multi-cycle multiply/divide operation.
// A countdown FSM (IDLE -> BUSY -> DONE) times the op, the destination is
// latched at issue and a valid bit marks it as a scoreboard entry.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   i_md_start_ex           op leaves EX this cycle
//   i_md_dest_ex            destination register of that op
//   i_rs_id, i_rt_id        ID source registers to check against the entry
//   o_busy_rs, o_busy_rt    ID source is the pending destination (BUSY only)
//   o_md_busy               unit occupied (BUSY or DONE)
//   o_md_done               one-cycle writeback strobe (DONE)
//   o_md_wb_addr            latched destination register
//   o_state                 FSM state for observation
module md_scoreboard
  import hazard_ctrl_md_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LAT     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_md_start_ex,
  input  logic [REG_ADDR_W-1:0] i_md_dest_ex,
  input  logic [REG_ADDR_W-1:0] i_rs_id,
  input  logic [REG_ADDR_W-1:0] i_rt_id,
  output logic                  o_busy_rs,
  output logic                  o_busy_rt,
  output logic                  o_md_busy,
  output logic                  o_md_done,
  output logic [REG_ADDR_W-1:0] o_md_wb_addr,
  output md_state_e             o_state
);

  // Counter holds the remaining BUSY cycles; DONE follows the count=1 cycle,
  // which puts md_done exactly MD_LAT cycles after the start.
  localparam logic [3:0] LAT_LOAD = 4'(MD_LAT - 1);

  md_state_e             r_state;
  md_state_e             w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [REG_ADDR_W-1:0] w_dest_nxt;
  logic                  r_sb_valid;
  logic                  w_sb_valid_nxt;
  logic                  w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= MD_IDLE;
      r_cnt      <= '0;
      r_dest     <= '0;
      r_sb_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dest     <= w_dest_nxt;
      r_sb_valid <= w_sb_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_dest_nxt     = r_dest;
    w_sb_valid_nxt = r_sb_valid;
    w_load         = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (i_md_start_ex) w_load = 1'b1;
      end
      MD_BUSY: begin
        // A start here is a protocol error and is dropped.
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = MD_DONE;
      end
      MD_DONE: begin
        w_state_nxt    = MD_IDLE;
        w_sb_valid_nxt = 1'b0;
        // Back-to-back issue: the result retires while the next op starts.
        if (i_md_start_ex) w_load = 1'b1;
      end
      default: begin
        w_state_nxt = MD_IDLE;
      end
    endcase
    if (w_load) begin
      w_state_nxt    = MD_BUSY;
      w_cnt_nxt      = LAT_LOAD;
      w_dest_nxt     = i_md_dest_ex;
      // r0 is never tracked, so a dest of 0 leaves no scoreboard entry.
      w_sb_valid_nxt = (i_md_dest_ex != '0);
    end
  end

  // In DONE the result is forwardable, so only BUSY holds dependants.
  assign o_busy_rs    = (r_state == MD_BUSY) && r_sb_valid && (r_dest == i_rs_id);
  assign o_busy_rt    = (r_state == MD_BUSY) && r_sb_valid && (r_dest == i_rt_id);
  assign o_md_busy    = (r_state != MD_IDLE);
  assign o_md_done    = (r_state == MD_DONE);
  assign o_md_wb_addr = r_dest;
  assign o_state      = r_state;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    assert (!(i_md_start_ex && (r_state == MD_BUSY)))
      else $error("md_scoreboard: md_start_ex while MD unit busy, start ignored");
  end
`endif

endmodule

// File: rtl/hazard_ctrl_md.sv
// Pipeline hazard controller for the 5-stage core: EX and ID-branch
// forwarding selects, load-use / branch / MD-scoreboard stalls, branch
// flush, and a saturating count of stall cycles.
// Ports:
//   clk, rst_n                            clock, async active-low reset
//   rs_id, rt_id, use_rs_id, use_rt_id    ID sources and whether they are read
//   branch_id, branch_taken_id            ID branch compare and its outcome
//   rs_ex, rt_ex                          EX sources
//   reg_write_*/mem_read_*/reg_write_addr_*  writers in EX, MEM, WB
//   md_start_ex, md_dest_ex               MD op issue and its destination
//   fwd_a, fwd_b                          EX operand selects
//   fwd_a2, fwd_b2                        ID branch operand selects
//   stall_if, flush_ex, flush_if          pipeline-register control
//   md_busy, md_done, md_wb_addr          MD unit status and writeback
//   stall_cnt                             saturating stall-cycle count
//   md_state_dbg                          MD FSM state for observation
module hazard_ctrl_md
  import hazard_ctrl_md_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32,
  parameter int MD_LAT     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic                  use_rs_id,
  input  logic                  use_rt_id,
  input  logic                  branch_id,
  input  logic                  branch_taken_id,
  input  logic [REG_ADDR_W-1:0] rs_ex,
  input  logic [REG_ADDR_W-1:0] rt_ex,
  input  logic                  reg_write_ex,
  input  logic                  mem_read_ex,
  input  logic [REG_ADDR_W-1:0] reg_write_addr_ex,
  input  logic                  reg_write_mem,
  input  logic                  mem_read_mem,
  input  logic [REG_ADDR_W-1:0] reg_write_addr_mem,
  input  logic                  reg_write_wb,
  input  logic [REG_ADDR_W-1:0] reg_write_addr_wb,
  input  logic                  md_start_ex,
  input  logic [REG_ADDR_W-1:0] md_dest_ex,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [1:0]            fwd_a2,
  output logic [1:0]            fwd_b2,
  output logic                  stall_if,
  output logic                  flush_ex,
  output logic                  flush_if,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [REG_ADDR_W-1:0] md_wb_addr,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [1:0]            md_state_dbg
);

  // Register 0 never matches anything.
  function automatic logic hit(input logic [REG_ADDR_W-1:0] a,
                               input logic [REG_ADDR_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // Shared priority mux: stage-1 writer, then stage-2 writer, then MD result.
  function automatic fwd_bus_t fwd_sel(input logic                  r_hit1,
                                       input logic                  r_hit2,
                                       input logic                  r_hit_md);
    if (r_hit1)        return FWD_MEM;
    else if (r_hit2)   return FWD_WB;
    else if (r_hit_md) return FWD_MD;
    else               return FWD_NO;
  endfunction

  logic                  w_busy_rs;
  logic                  w_busy_rt;
  logic                  w_md_done;
  logic [REG_ADDR_W-1:0] w_md_wb_addr;
  md_state_e             w_md_state;
  logic                  w_ex_alu_wr;
  logic                  w_mem_alu_wr;
  logic                  w_stall_rs;
  logic                  w_stall_rt;
  logic                  w_stall;
  logic [CNT_W-1:0]      r_stall_cnt;

  md_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .MD_LAT     (MD_LAT)
  ) u_md_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_md_start_ex (md_start_ex),
    .i_md_dest_ex  (md_dest_ex),
    .i_rs_id       (rs_id),
    .i_rt_id       (rt_id),
    .o_busy_rs     (w_busy_rs),
    .o_busy_rt     (w_busy_rt),
    .o_md_busy     (md_busy),
    .o_md_done     (w_md_done),
    .o_md_wb_addr  (w_md_wb_addr),
    .o_state       (w_md_state)
  );

  // EX operand forwarding.
  assign fwd_a = fwd_sel(reg_write_mem && hit(rs_ex, reg_write_addr_mem),
                         reg_write_wb  && hit(rs_ex, reg_write_addr_wb),
                         w_md_done     && hit(rs_ex, w_md_wb_addr));
  assign fwd_b = fwd_sel(reg_write_mem && hit(rt_ex, reg_write_addr_mem),
                         reg_write_wb  && hit(rt_ex, reg_write_addr_wb),
                         w_md_done     && hit(rt_ex, w_md_wb_addr));

  // ID branch forwarding: a load result is not available yet in EX or MEM,
  // so only non-load writers are forwarded; loads are covered by stalls.
  assign w_ex_alu_wr  = reg_write_ex  && !mem_read_ex;
  assign w_mem_alu_wr = reg_write_mem && !mem_read_mem;

  assign fwd_a2 = fwd_sel(w_ex_alu_wr  && hit(rs_id, reg_write_addr_ex),
                          w_mem_alu_wr && hit(rs_id, reg_write_addr_mem),
                          w_md_done    && hit(rs_id, w_md_wb_addr));
  assign fwd_b2 = fwd_sel(w_ex_alu_wr  && hit(rt_id, reg_write_addr_ex),
                          w_mem_alu_wr && hit(rt_id, reg_write_addr_mem),
                          w_md_done    && hit(rt_id, w_md_wb_addr));

  // Stall sources per operand: load-use, branch on an EX ALU result,
  // branch on a load now in MEM (second cycle of a branch-after-load),
  // and an MD destination still in flight.
  assign w_stall_rs = use_rs_id && (
                        (mem_read_ex && hit(rs_id, reg_write_addr_ex)) ||
                        (branch_id && w_ex_alu_wr && hit(rs_id, reg_write_addr_ex)) ||
                        (branch_id && mem_read_mem && hit(rs_id, reg_write_addr_mem)) ||
                        w_busy_rs);
  assign w_stall_rt = use_rt_id && (
                        (mem_read_ex && hit(rt_id, reg_write_addr_ex)) ||
                        (branch_id && w_ex_alu_wr && hit(rt_id, reg_write_addr_ex)) ||
                        (branch_id && mem_read_mem && hit(rt_id, reg_write_addr_mem)) ||
                        w_busy_rt);
  assign w_stall = w_stall_rs || w_stall_rt;

  assign stall_if = w_stall;
  assign flush_ex = w_stall;
  // A taken branch squashes fetch only once its operands are ready.
  assign flush_if = branch_taken_id && !w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((w_stall == ENABLED) && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign md_done      = w_md_done;
  assign md_wb_addr   = w_md_wb_addr;
  assign stall_cnt    = r_stall_cnt;
  assign md_state_dbg = w_md_state;

endmodule

// File: doc/hazard_ctrl_md.md
Name: hazard_ctrl_md

Overview:
Next-generation pipeline hazard controller for the 5-stage MIPS core. It produces the EX-stage operand forwarding selects and the ID-stage branch-compare forwarding selects. It also generates load-use and branch-dependency stalls, and branch flushes. It owns a scoreboard and countdown FSM for one outstanding multi-cycle multiply/divide whose result retires on a dedicated register-file write port. It sits beside the decoder and drives the IF/ID and ID/EX pipeline-register enables and flushes.

Parameters:
REG_ADDR_W, 5, register address width
NUM_REGS, 32, architectural registers (2**REG_ADDR_W)
MD_LAT, 4, cycles from md_start_ex to md_done (legal range 2..15)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  core clock
rst_n  in  1  reset
rs_id, rt_id  in  REG_ADDR_W  source regs of instruction in ID
use_rs_id, use_rt_id  in  1  ID instruction actually reads rs / rt
branch_id  in  1  ID instruction is a branch compare
branch_taken_id  in  1  branch resolved taken in ID
rs_ex, rt_ex  in  REG_ADDR_W  source regs in EX
reg_write_ex, mem_read_ex  in  1  EX writes reg / is a load
reg_write_addr_ex  in  REG_ADDR_W
reg_write_mem, mem_read_mem  in  1
reg_write_addr_mem  in  REG_ADDR_W
reg_write_wb  in  1
reg_write_addr_wb  in  REG_ADDR_W
md_start_ex  in  1  multi-cycle op leaves EX this cycle
md_dest_ex  in  REG_ADDR_W  destination of that op
fwd_a, fwd_b  out  2  EX operand selects
fwd_a2, fwd_b2  out  2  ID branch operand selects
stall_if  out  1  hold PC and IF/ID
flush_ex  out  1  insert bubble into ID/EX
flush_if  out  1  squash IF/ID
md_busy  out  1  MD unit occupied
md_done  out  1  one-cycle MD writeback strobe
md_wb_addr  out  REG_ADDR_W  MD writeback register
stall_cnt  out  CNT_W  cycles with stall_if=1, saturating

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset values: FSM IDLE, md_busy=0, md_done=0, md_wb_addr=0, stall_cnt=0, scoreboard clear. Combinational outputs follow inputs.
- Forwarding codes: FWD_NO=0, FWD_MEM=1, FWD_WB=2, FWD_MD=3. Register 0 never matches anything.
- fwd_a/fwd_b priority:
  - MEM write match -> FWD_MEM.
  - Else WB write match -> FWD_WB.
  - Else md_done and md_wb_addr match -> FWD_MD.
  - Else FWD_NO.
- fwd_a2/fwd_b2 (ID stage, used only when branch_id=1):
  - EX non-load write match -> FWD_MEM (EX result path).
  - Else MEM non-load write match -> FWD_WB.
  - Else md_done match -> FWD_MD.
  - Else FWD_NO.
- Stall sources are combinational, each qualified by use_rs_id / use_rt_id and a nonzero register:
  - (a) load-use: mem_read_ex and reg_write_addr_ex matches.
  - (b) branch_id with reg_write_ex match on a non-load: 1 stall cycle.
  - (c) branch_id with load in EX: held by (a). The following cycle the load is in MEM, so branch_id with mem_read_mem match stalls again (2 total).
  - (d) scoreboard: the register is busy while the FSM is BUSY.
  - (e) structural: the ID instruction is a new MD op while md_busy=1. The decoder signals this by asserting md_start_ex next cycle; to detect it here, the decoder qualifies with md_busy and raises use_rs_id.
  - stall_if = OR of all sources; flush_ex = stall_if.
- flush_if = branch_taken_id and not stall_if.
- MD FSM:
  - IDLE: on md_start_ex go to BUSY. Load count = MD_LAT-1, latch md_dest_ex, set md_busy.
  - BUSY: decrement each cycle. At count=1 go to DONE.
  - DONE: md_done=1 for exactly one cycle, md_wb_addr valid, md_busy still 1. Next state IDLE. A md_start_ex arriving in DONE goes directly to BUSY (back-to-back issue).
  - md_start_ex with md_dest_ex=0: FSM runs normally, no scoreboard bit, no forwarding.
  - md_start_ex while BUSY is a protocol error; ignore it and assert a simulation-only error message.
- Scoreboard is a single latched address plus valid bit, because only one op is outstanding.
- stall_cnt increments when stall_if=1 and holds at all-ones.
- Reset mid-operation: FSM returns to IDLE immediately and no md_done is produced.

Decomposition:
- Package defines.v: FWD_NO/FWD_MEM/FWD_WB/FWD_MD, FwdBus, RegAddrBus, ENABLED/DISABLED, MD FSM state encodings.
- One sub-module, md_scoreboard: FSM, counter, latched destination, md_busy/md_done/md_wb_addr, and a busy-match output.
- Top level holds the forwarding muxes, stall OR-tree, flush logic and stall counter.

Test Plan:
- Forwarding priority: EX rs_ex=3; MEM writes r3 and WB writes r3 -> fwd_a=1. Remove MEM -> fwd_a=2. rs_ex=0 with all writers at r0 -> fwd_a=0.
- Load-use: lw r5 in EX, ID add uses rt=r5 -> stall_if=1, flush_ex=1 for 1 cycle, then fwd_b=2 next cycle; stall_cnt=1.
- Branch after load: lw r7, then beq r7 in ID -> stall 2 cycles, then fwd_a2=0 with value from regfile via WB; flush_if only after stall clears when taken.
- MD: MD_LAT=4, md_start_ex dest r9 -> md_busy for cycles 1..4, md_done at cycle 4, add r9 in ID stalls cycles 1..3, fwd_a2/fwd_a=3 in done cycle.
- Back-to-back MD: md_start_ex in DONE cycle -> md_busy never drops, second md_done exactly MD_LAT cycles later.
- rst_n low during BUSY -> md_busy=0 asynchronously, no md_done, stall_cnt=0.
